// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: FIFO read port plus valid/ready output stream used by fifo_rd_ctrl
interface fifo_rd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_counter;
  logic [DATA_W-1:0] fifo_out;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  modport master (
    input  fifo_empty, fifo_counter, fifo_out, m_ready,
    output fifo_rd_en, m_data, m_valid
  );
  modport slave (
    output fifo_empty, fifo_counter, fifo_out, m_ready,
    input  fifo_rd_en, m_data, m_valid
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read controller with 2-entry skid buffer and valid/ready output.
// Optional burst gating (IDLE/DRAIN FSM with idle timeout) enabled by FIFO_RD_BURST_EN.
module fifo_rd_ctrl #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_rd_ctrl_if.master bus,
  output logic           busy_o,
  output logic [15:0]    word_cnt_o
);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t            state_q;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [1:0]        credit;
  logic              pop, rd_en, eligible, nonempty, wr_tail;
  assign credit   = occ_q + {1'b0, inflight_q};
  assign pop      = bus.m_valid & bus.m_ready;
  assign nonempty = ~bus.fifo_empty & (|bus.fifo_counter);
  assign eligible = state_q == DRAIN;
  assign rd_en    = eligible & nonempty & ((credit < 2'd2) | ((credit == 2'd2) & pop));
  assign wr_tail  = (occ_q == 2'd1) & ~pop;
  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = occ_q != 2'd0;
  assign bus.m_data     = head_q;
  assign busy_o         = (state_q == DRAIN) | inflight_q | (occ_q != 2'd0);
  assign word_cnt_o     = word_cnt_q;
  // next state of the skid buffer: pop shifts tail to head, a returning read lands behind the head
  always_comb begin
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    inflight_d = rd_en;
    head_d     = (inflight_q & ~wr_tail) ? bus.fifo_out : pop ? tail_q : head_q;
    tail_d     = (inflight_q & wr_tail) ? bus.fifo_out : tail_q;
    word_cnt_d = word_cnt_q + {15'd0, pop};
  end
  // buffer, credit and transfer counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      word_cnt_q <= word_cnt_d;
    end
  end
`ifdef FIFO_RD_BURST_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q;
  // burst gate: wait for BURST_LEN words or TIMEOUT idle cycles, then drain until empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else if (state_q == IDLE) begin
      if ((bus.fifo_counter >= CNT_W'(BURST_LEN)) || (timer_q == TW'(TIMEOUT))) begin
        state_q <= DRAIN;
        timer_q <= '0;
      end else begin
        timer_q <= bus.fifo_empty ? '0 : timer_q + 1'b1;
      end
    end else if (bus.fifo_empty && !inflight_q) begin
      state_q <= IDLE;
    end
  end
`else
  // without burst gating the controller drains continuously once out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= DRAIN;
  end
`endif
  // credit rule: buffered plus in-flight words can never exceed the two buffer slots
  a_credit: assert property (@(posedge clk) disable iff (!rst_n) credit <= 2'd2);
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized scoreboard bench for fifo_rd_ctrl with a behavioural FIFO
module tb_fifo_rd_ctrl;
  localparam int DW = 8;
  localparam int CW = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] word_cnt;
  logic [7:0]  fq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  xd_log[$];
  int          rd_log[$];
  int          xc_log[$];
  int          nvec = 0, nerr = 0, cyc = 0, total = 0;
  logic [15:0] wc = '0;
  always #5 clk = ~clk;
  fifo_rd_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) ifc ();
  fifo_rd_ctrl #(.DATA_W(DW), .CNT_W(CW), .BURST_LEN(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc), .busy_o(busy), .word_cnt_o(word_cnt)
  );
  task automatic upd();
    ifc.fifo_empty   = (fq.size() == 0);
    ifc.fifo_counter = CW'(fq.size());
  endtask
  task automatic push(input logic [7:0] d);
    if (fq.size() < 8) begin
      fq.push_back(d);
      exp_q.push_back(d);
    end
    upd();
  endtask
  task automatic clr_logs();
    rd_log.delete();
    xc_log.delete();
    xd_log.delete();
  endtask
  task automatic step();
    logic p_rd, p_v, p_r;
    logic [7:0] p_d, e;
    #1;
    p_rd = ifc.fifo_rd_en;
    p_v  = ifc.m_valid;
    p_r  = ifc.m_ready;
    p_d  = ifc.m_data;
    if (p_rd) rd_log.push_back(cyc);
    @(posedge clk);
    #1;
    if (p_rd) begin
      nvec++;
      if (fq.size() == 0) begin
        nerr++;
        $display("FAIL pop_empty: rd_en=1 with FIFO empty at cycle %0d", cyc);
      end else ifc.fifo_out = fq.pop_front();
    end
    if (p_v && p_r) begin
      wc++;
      total++;
      xc_log.push_back(cyc);
      xd_log.push_back(p_d);
      nvec++;
      if (exp_q.size() == 0) begin
        nerr++;
        $display("FAIL order: got %0h expected no transfer at cycle %0d", p_d, cyc);
      end else begin
        e = exp_q.pop_front();
        if (p_d !== e) begin
          nerr++;
          $display("FAIL order: got %0h expected %0h at cycle %0d", p_d, e, cyc);
        end
      end
    end
    if (p_v && !p_r) begin
      nvec++;
      if (ifc.m_valid !== 1'b1 || ifc.m_data !== p_d) begin
        nerr++;
        $display("FAIL hold: got v=%0b d=%0h expected v=1 d=%0h", ifc.m_valid, ifc.m_data, p_d);
      end
    end
    nvec++;
    if (exp_q.size() - fq.size() > 2) begin
      nerr++;
      $display("FAIL credit: got %0d outstanding expected <=2", exp_q.size() - fq.size());
    end
    cyc++;
    upd();
  endtask
  task automatic drain();
    int n = 0;
    ifc.m_ready = 1'b1;
    while ((exp_q.size() != 0 || ifc.m_valid) && n < 80) begin
      step();
      n++;
    end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d words left expected 0", exp_q.size());
    end
  endtask
  task automatic test_reset();
    ifc.m_ready  = 1'b0;
    ifc.fifo_out = '0;
    upd();
    #1;
    nvec++;
    if ({ifc.fifo_rd_en, ifc.m_valid, ifc.m_data, busy, word_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset_pwr: got %0h expected 0", {ifc.fifo_rd_en, ifc.m_valid, ifc.m_data, busy, word_cnt});
    end
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    for (int i = 0; i < 8; i++) step();
    nvec++;
    if (ifc.m_valid !== 1'b1 || ifc.fifo_rd_en !== 1'b0) begin
      nerr++;
      $display("FAIL reset_pre: got v=%0b rd=%0b expected v=1 rd=0", ifc.m_valid, ifc.fifo_rd_en);
    end
    rst_n = 1'b0;
    #1;
    exp_q = fq;
    wc = '0;
    nvec++;
    if ({ifc.fifo_rd_en, ifc.m_valid, ifc.m_data, busy, word_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset_mid: got %0h expected 0", {ifc.fifo_rd_en, ifc.m_valid, ifc.m_data, busy, word_cnt});
    end
    ifc.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++;
      if (ifc.fifo_rd_en !== 1'b0 || ifc.m_valid !== 1'b0) begin
        nerr++;
        $display("FAIL reset_hold: got rd=%0b v=%0b expected 0 0", ifc.fifo_rd_en, ifc.m_valid);
      end
      step();
    end
    rst_n = 1'b1;
    drain();
  endtask
  task automatic test_stream();
    int n = 0;
    logic [15:0] w0 = wc;
    ifc.m_ready = 1'b1;
    clr_logs();
    push(8'd10);
    push(8'd20);
    push(8'd30);
    while (xc_log.size() < 3 && n < 40) begin
      step();
      n++;
    end
    nvec++;
    if (xc_log.size() != 3 || rd_log.size() == 0) begin
      nerr++;
      $display("FAIL stream_cnt: got %0d transfers expected 3", xc_log.size());
    end else begin
      nvec++;
      if (xc_log[0] != rd_log[0] + 2 || xc_log[1] != xc_log[0] + 1 || xc_log[2] != xc_log[0] + 2) begin
        nerr++;
        $display("FAIL stream_lat: got rd@%0d xfers@%0d,%0d,%0d expected rd+2 consecutive",
                 rd_log[0], xc_log[0], xc_log[1], xc_log[2]);
      end
      nvec++;
      if (xd_log[0] !== 8'd10 || xd_log[1] !== 8'd20 || xd_log[2] !== 8'd30) begin
        nerr++;
        $display("FAIL stream_data: got %0d,%0d,%0d expected 10,20,30", xd_log[0], xd_log[1], xd_log[2]);
      end
    end
    nvec++;
    if (word_cnt !== w0 + 16'd3) begin
      nerr++;
      $display("FAIL stream_wcnt: got %0d expected %0d", word_cnt, w0 + 16'd3);
    end
  endtask
  task automatic test_backpressure();
    logic [7:0] w[4];
    ifc.m_ready = 1'b0;
    clr_logs();
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom);
      push(w[i]);
    end
    for (int i = 0; i < 12; i++) step();
    nvec++;
    if (rd_log.size() != 2) begin
      nerr++;
      $display("FAIL bp_pops: got %0d expected 2", rd_log.size());
    end
    nvec++;
    if (ifc.m_valid !== 1'b1 || ifc.fifo_rd_en !== 1'b0 || ifc.m_data !== w[0]) begin
      nerr++;
      $display("FAIL bp_stall: got v=%0b rd=%0b d=%0h expected v=1 rd=0 d=%0h",
               ifc.m_valid, ifc.fifo_rd_en, ifc.m_data, w[0]);
    end
    drain();
    nvec++;
    if (xd_log.size() != 4) begin
      nerr++;
      $display("FAIL bp_count: got %0d expected 4", xd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (xd_log[i] !== w[i]) begin
          nerr++;
          $display("FAIL bp_data: got %0h expected %0h at %0d", xd_log[i], w[i], i);
        end
      end
    end
  endtask
  task automatic test_empty();
    for (int i = 0; i < 20; i++) begin
      ifc.m_ready = 1'($urandom);
      #1;
      nvec++;
      if (ifc.fifo_rd_en !== 1'b0 || ifc.m_valid !== 1'b0) begin
        nerr++;
        $display("FAIL empty: got rd=%0b v=%0b expected 0 0", ifc.fifo_rd_en, ifc.m_valid);
      end
      step();
    end
  endtask
  task automatic test_burst();
    int c0;
`ifdef FIFO_RD_BURST_EN
    int n = 0;
    ifc.m_ready = 1'b1;
    clr_logs();
    c0 = cyc;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    for (int i = 0; i < 15; i++) step();
    nvec++;
    if (rd_log.size() != 0) begin
      nerr++;
      $display("FAIL burst_wait: got %0d pops expected 0", rd_log.size());
    end
    while (xc_log.size() < 3 && n < 30) begin
      step();
      n++;
    end
    nvec++;
    if (xc_log.size() != 3 || rd_log[0] != c0 + 16) begin
      nerr++;
      $display("FAIL burst_timeout: got %0d xfers first rd@%0d expected 3 @%0d", xc_log.size(),
               rd_log.size() ? rd_log[0] : -1, c0 + 16);
    end
    step();
    step();
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL burst_idle: got busy=%0b expected 0", busy);
    end
    clr_logs();
    c0 = cyc;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    for (int i = 0; i < 3; i++) step();
    nvec++;
    if (rd_log.size() == 0 || rd_log[0] != c0 + 1) begin
      nerr++;
      $display("FAIL burst_len: got first rd@%0d expected @%0d", rd_log.size() ? rd_log[0] : -1, c0 + 1);
    end
    drain();
    step();
    step();
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL burst_end: got busy=%0b expected 0", busy);
    end
`else
    ifc.m_ready = 1'b1;
    clr_logs();
    c0 = cyc;
    push(8'($urandom));
    step();
    nvec++;
    if (rd_log.size() == 0 || rd_log[0] != c0) begin
      nerr++;
      $display("FAIL immediate: got first rd@%0d expected @%0d", rd_log.size() ? rd_log[0] : -1, c0);
    end
    drain();
`endif
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ifc.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      step();
    end
    drain();
    nvec++;
    if (word_cnt !== wc) begin
      nerr++;
      $display("FAIL rand_wcnt: got %0d expected %0d", word_cnt, wc);
    end
  endtask
  task automatic test_wrap();
    int t0, n = 0;
    rst_n = 1'b0;
    #1;
    exp_q = fq;
    wc = '0;
    step();
    rst_n = 1'b1;
    ifc.m_ready = 1'b1;
    t0 = total;
    while (total - t0 < 65535 && n < 70000) begin
      if (fq.size() < 8) push(8'($urandom));
      step();
      n++;
    end
    nvec++;
    if (word_cnt !== 16'hFFFF) begin
      nerr++;
      $display("FAIL wrap_max: got %0h expected ffff", word_cnt);
    end
    while (total - t0 < 65536 && n < 70000) begin
      step();
      n++;
    end
    nvec++;
    if (word_cnt !== 16'h0000) begin
      nerr++;
      $display("FAIL wrap_zero: got %0h expected 0", word_cnt);
    end
    drain();
    nvec++;
    if (word_cnt !== wc) begin
      nerr++;
      $display("FAIL wrap_wcnt: got %0h expected %0h", word_cnt, wc);
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_empty();
    test_burst();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
